// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate-operand stage:
//   - immediate type codes presented on in_type
//   - occupancy state encoding of the 2-entry skid buffer
//   - XLEN legality check used at elaboration of the top level
// ----------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_R    = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_RSVD = 3'd6,
        IMM_Z    = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    // Only RV32 and RV64 immediate widths are meaningful for this stage.
    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_operand_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_operand_pipe_if
// Bundles the decode-side (in_*) and operand-select-side (out_*) handshakes of
// the immediate-operand stage together with the synchronous flush.
//   slave  : view used by imm_operand_pipe
//   master : view used by whatever drives the stage (decode + consumer)
// Parameters: XLEN (immediate width), TAG_W (side-band tag width).
// ----------------------------------------------------------------------------
interface imm_operand_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:7]       in_instr;
    logic [2:0]        in_type;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_type, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_type, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_expand.sv
// ----------------------------------------------------------------------------
// imm_expand
// Purely combinational RISC-V immediate expander.
//   instr   [31:7]  instruction bits without the opcode
//   imm_type [2:0]  immediate type code (imm_pkg::imm_type_e)
//   imm     XLEN    expanded immediate
//   illegal 1       type code not supported by this build
// Build option: IMM_ZTYPE_EN enables code 7 as the CSR zimm (Z) immediate;
// without it code 7 is flagged illegal like the reserved code 6.
// ----------------------------------------------------------------------------
module imm_expand
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32_s;

    // Build the 32-bit immediate for each format; bit 31 carries the sign.
    always_comb begin
        imm32_s = 32'd0;
        illegal = 1'b0;
        case (imm_type)
            IMM_R:    imm32_s = 32'd0;
            IMM_I:    imm32_s = {{21{instr[31]}}, instr[30:20]};
            IMM_S:    imm32_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:    imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:    imm32_s = {instr[31:12], 12'd0};
            IMM_J:    imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_RSVD: begin
                imm32_s = 32'd0;
                illegal = 1'b1;
            end
`ifdef IMM_ZTYPE_EN
            IMM_Z:    imm32_s = {27'd0, instr[19:15]};
`else
            IMM_Z: begin
                imm32_s = 32'd0;
                illegal = 1'b1;
            end
`endif
            default: begin
                imm32_s = 32'd0;
                illegal = 1'b1;
            end
        endcase
    end

    // Every signed format has bit 31 = sign and the zero-filled formats have
    // bit 31 = 0, so a signed widening covers all of them (including U on RV64).
    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_operand_pipe.sv
// ----------------------------------------------------------------------------
// imm_operand_pipe
// Registered immediate-operand stage: expands the immediate at enqueue and
// holds up to two expanded entries (head/tail) in a valid/ready skid buffer
// between decode and operand select, carrying a side-band tag per entry.
// Ports:
//   clk   pipeline clock
//   rst   asynchronous active-high reset (drops all entries, zeroes head)
//   bus   imm_operand_pipe_if.slave: flush, in_valid/in_ready/in_instr/
//         in_type/in_tag, out_valid/out_ready/out_imm/out_tag/out_illegal
// Build option: IMM_ZTYPE_EN (see imm_expand) selects Z-type for code 7.
// ----------------------------------------------------------------------------
module imm_operand_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    imm_operand_pipe_if.slave  bus
);

    if (!xlen_is_legal(XLEN)) begin : g_xlen_check
        $error("imm_operand_pipe: XLEN must be 32 or 64");
    end

    occ_state_e       state_r;
    occ_state_e       state_next_s;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             load_head_new_s;
    logic             load_head_tail_s;
    logic             load_tail_s;

    logic [XLEN-1:0]  exp_imm_s;
    logic             exp_ill_s;
    logic [XLEN-1:0]  head_imm_r;
    logic [XLEN-1:0]  tail_imm_r;
    logic             head_ill_r;
    logic             tail_ill_r;
    logic [TAG_W-1:0] head_tag_r;
    logic [TAG_W-1:0] tail_tag_r;

    imm_expand #(.XLEN(XLEN)) u_expand (
        .instr    (bus.in_instr),
        .imm_type (bus.in_type),
        .imm      (exp_imm_s),
        .illegal  (exp_ill_s)
    );

    // in_ready is held low while reset is asserted so nothing is accepted.
    assign in_ready_s  = (state_r != OCC_FULL) && !rst;
    assign out_valid_s = (state_r != OCC_EMPTY);
    assign push_s      = bus.in_valid && in_ready_s;
    assign pop_s       = out_valid_s && bus.out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next occupancy and entry-movement selects; flush overrides any push.
    always_comb begin
        state_next_s     = state_r;
        load_head_new_s  = 1'b0;
        load_head_tail_s = 1'b0;
        load_tail_s      = 1'b0;
        if (bus.flush) begin
            state_next_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (push_s) begin
                        state_next_s    = OCC_ONE;
                        load_head_new_s = 1'b1;
                    end else begin
                        state_next_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (push_s && pop_s) begin
                        state_next_s    = OCC_ONE;
                        load_head_new_s = 1'b1;
                    end else if (push_s) begin
                        state_next_s = OCC_FULL;
                        load_tail_s  = 1'b1;
                    end else if (pop_s) begin
                        state_next_s = OCC_EMPTY;
                    end else begin
                        state_next_s = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    if (pop_s) begin
                        state_next_s     = OCC_ONE;
                        load_head_tail_s = 1'b1;
                    end else begin
                        state_next_s = OCC_FULL;
                    end
                end
                default: begin
                    state_next_s = OCC_EMPTY;
                end
            endcase
        end
    end

    // Head entry: loaded from the expander or promoted from the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_imm_r <= '0;
            head_ill_r <= 1'b0;
            head_tag_r <= '0;
        end else if (load_head_new_s) begin
            head_imm_r <= exp_imm_s;
            head_ill_r <= exp_ill_s;
            head_tag_r <= bus.in_tag;
        end else if (load_head_tail_s) begin
            head_imm_r <= tail_imm_r;
            head_ill_r <= tail_ill_r;
            head_tag_r <= tail_tag_r;
        end
    end

    // Tail (skid) entry: captures a push that arrives while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_imm_r <= '0;
            tail_ill_r <= 1'b0;
            tail_tag_r <= '0;
        end else if (load_tail_s) begin
            tail_imm_r <= exp_imm_s;
            tail_ill_r <= exp_ill_s;
            tail_tag_r <= bus.in_tag;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_imm     = head_imm_r;
    assign bus.out_tag     = head_tag_r;
    assign bus.out_illegal = head_ill_r;

endmodule
